serial_loader: RTL and testbench
================================

SERIAL_LOADER -- requirements
Module: serial_loader

Interface
REQ-001 SHALL have parameter WIDTH, default 7, meaning the assembled word width; it matches the downstream 7-bit register input.
REQ-002 SHALL have parameter LSB_FIRST, default 1, meaning 1 = first serial bit lands in bit 0, and 0 = first serial bit lands in bit WIDTH-1.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1, which requests a new frame.
REQ-006 SHALL have port sin, input, 1, the serial data bit.
REQ-007 SHALL have port ready, input, 1, the downstream accept.
REQ-008 SHALL have port d_out, output, WIDTH, the assembled parallel word that feeds the register d input.
REQ-009 SHALL have port valid, output, 1, meaning d_out holds a complete frame.
REQ-010 SHALL have port busy, output, 1, high in state SHIFT.
REQ-011 SHALL have port overrun, output, 1, a sticky flag for a start request that was lost.

Function
REQ-012 SHALL implement a three-state FSM:
- IDLE: nothing pending.
- SHIFT: receiving bits.
- HOLD: word presented and awaiting ready.
REQ-013 In IDLE with start=1, SHALL go to SHIFT at the next edge and clear the bit counter; sin is not sampled in the start cycle.
REQ-014 In SHIFT, SHALL sample sin on every edge into a shift register per LSB_FIRST and increment the bit counter by 1.
REQ-015 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and never exceed WIDTH.
REQ-016 On the edge capturing bit WIDTH-1, SHALL transfer the complete word to d_out, set valid=1 and go to HOLD.
REQ-017 Latency SHALL be fixed: start sampled at edge N, bits sampled at edges N+1..N+WIDTH, valid=1 after edge N+WIDTH.
REQ-018 d_out SHALL change only on the completing edge of REQ-016, and SHALL stay stable while valid=1 and after the handshake until the next word completes.
REQ-019 In HOLD, valid SHALL stay 1 until an edge with ready=1; at that edge valid goes 0.
REQ-020 At that handshake edge the FSM SHALL go to IDLE if start=0, or directly to SHIFT if start=1 (back-to-back frames, no bubble).
REQ-021 ready SHALL be ignored outside HOLD.
REQ-022 start=1 while in SHIFT SHALL be ignored for framing and SHALL set overrun=1.
REQ-023 start=1 while in HOLD with ready=0 SHALL be ignored for framing and SHALL set overrun=1.
REQ-024 overrun SHALL remain 1 until reset.
REQ-025 busy SHALL equal (state==SHIFT); valid SHALL equal (state==HOLD); both SHALL be registered (no combinational path from inputs).
REQ-026 No output SHALL depend combinationally on start, sin or ready.

Reset
REQ-027 reset=1 SHALL asynchronously force state=IDLE, bit counter=0, shift register=0, d_out=0, valid=0, busy=0, overrun=0, independent of clk.
REQ-028 Reset asserted mid-SHIFT or mid-HOLD SHALL discard the partial or pending word.
REQ-029 After reset deasserts, the first start SHALL behave exactly as REQ-013.
REQ-030 Reset deassertion SHALL take effect at the first clk edge where reset=0.

Verification
REQ-031 Reset then idle: reset=1 for 20 ns, then 0, with start=0 -> d_out=7'b0000000, valid=0, busy=0, overrun=0 for 10 cycles.
REQ-032 LSB-first frame: start pulse, then sin=1,1,1,0,0,0,0 on 7 edges with ready=0 -> busy=1 for 7 cycles, valid=1 exactly 7 edges after start, d_out=7'b0000111 held stable for 5 further cycles.
REQ-033 Handshake and back-to-back: frame of REQ-032, then ready=1 and start=1 in the same cycle, then sin=1,0,1,0,1,0,1 -> valid drops for 7 cycles, busy=1 with no bubble, next d_out=7'b1010101, overrun=0.
REQ-034 Overrun: start=1 on the third SHIFT cycle -> frame still completes with the correct word, overrun=1 and stays 1 after valid handshake until reset.
REQ-035 Reset mid-operation: reset=1 after 4 bits shifted -> all outputs 0 immediately without waiting for a clk edge; a new full frame then yields the correct word.
REQ-036 MSB-first: LSB_FIRST=0, sin=0,0,0,0,1,1,1 -> d_out=7'b0000111.

Source files
------------

// File: rtl/serial_loader.sv
// Serial-to-parallel frame loader: shifts WIDTH bits after a start request and
// presents the word on d_out with a valid/ready handshake and a sticky overrun flag.
//
// state | meaning
// IDLE  | nothing pending
// SHIFT | receiving bits
// HOLD  | word presented, awaiting ready
module serial_loader #(
  parameter int WIDTH     = 7,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sin,
  input  logic             ready,
  output logic [WIDTH-1:0] d_out,
  output logic             valid,
  output logic             busy,
  output logic             overrun
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg, shift_nxt;
  logic             clr_cnt, shift_en, load, set_ovr;

  // The first bit ends up at bit 0 (LSB-first) or at bit WIDTH-1 (MSB-first).
  assign shift_nxt = LSB_FIRST ? {sin, shreg[WIDTH-1:1]} : {shreg[WIDTH-2:0], sin};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    clr_cnt   = 1'b0;
    shift_en  = 1'b0;
    load      = 1'b0;
    set_ovr   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SHIFT;
          clr_cnt   = 1'b1;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        set_ovr  = start;
        if (cnt == LAST) begin
          load      = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (ready) begin
          if (start) begin
            state_nxt = SHIFT;
            clr_cnt   = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          set_ovr = start;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      shreg   <= '0;
      d_out   <= '0;
      overrun <= 1'b0;
    end else begin
      if (clr_cnt)       cnt <= '0;
      else if (shift_en) cnt <= cnt + 1'b1;
      if (shift_en) shreg   <= shift_nxt;
      if (load)     d_out   <= shift_nxt;
      if (set_ovr)  overrun <= 1'b1;
    end
  end

  // Both flags decode the state register only, so no input reaches them combinationally.
  assign busy  = (state == SHIFT);
  assign valid = (state == HOLD);

endmodule

// File: tb/tb_serial_loader.sv
// Directed bench for serial_loader: an LSB-first and an MSB-first instance
// share all inputs; expected words are hand-computed.
module tb_serial_loader;

  logic       clk = 1'b0;
  logic       reset, start, sin, ready;
  logic [6:0] d_out, d_out_m;
  logic       valid, busy, overrun;
  logic       valid_m, busy_m, overrun_m;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_loader #(.WIDTH(7), .LSB_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .sin(sin), .ready(ready),
    .d_out(d_out), .valid(valid), .busy(busy), .overrun(overrun)
  );

  serial_loader #(.WIDTH(7), .LSB_FIRST(1'b0)) dut_m (
    .clk(clk), .reset(reset), .start(start), .sin(sin), .ready(ready),
    .d_out(d_out_m), .valid(valid_m), .busy(busy_m), .overrun(overrun_m)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Shift seven bits, bits[0] first; start is raised during bit index ov_idx (-1 = never).
  task automatic shift_bits(input logic [6:0] bits, input int ov_idx);
    for (int i = 0; i < 7; i++) begin
      sin   = bits[i];
      start = (i == ov_idx);
      tick();
      start = 1'b0;
      if (i < 6) begin
        check("busy_during_shift", 32'(busy), 32'd1);
        check("valid_during_shift", 32'(valid), 32'd0);
      end else begin
        check("valid_at_complete", 32'(valid), 32'd1);
        check("busy_at_complete", 32'(busy), 32'd0);
      end
    end
  endtask

  task automatic start_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    check("valid_after_start", 32'(valid), 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; sin = 1'b0; ready = 1'b0;
    #20 reset = 1'b0;

    // Reset then idle: everything stays zero.
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_outputs", {22'b0, d_out, valid, busy, overrun}, 32'd0);
    end

    // LSB-first frame 1,1,1,0,0,0,0 -> 0000111; MSB-first twin sees 1110000.
    start_frame();
    shift_bits(7'b0000111, -1);
    check("lsb_word", 32'(d_out), 32'h07);
    check("msb_twin_word", 32'(d_out_m), 32'h70);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_valid", 32'(valid), 32'd1);
      check("hold_stable", 32'(d_out), 32'h07);
    end

    // Handshake with start in the same cycle: straight back into SHIFT.
    ready = 1'b1; start = 1'b1;
    tick();
    ready = 1'b0; start = 1'b0;
    check("b2b_valid_drop", 32'(valid), 32'd0);
    check("b2b_busy", 32'(busy), 32'd1);
    check("b2b_dout_kept", 32'(d_out), 32'h07);
    shift_bits(7'b1010101, -1);
    check("b2b_word", 32'(d_out), 32'h55);
    check("b2b_no_overrun", 32'(overrun), 32'd0);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("release_valid", 32'(valid), 32'd0);
    check("release_idle", 32'(busy), 32'd0);
    check("release_dout_kept", 32'(d_out), 32'h55);

    // Start on the third SHIFT cycle: framing unaffected, overrun sticks.
    start_frame();
    shift_bits(7'b0100110, 2);
    check("ovr_word", 32'(d_out), 32'h26);
    check("ovr_flag", 32'(overrun), 32'd1);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("ovr_after_handshake_valid", 32'(valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ovr_sticky", 32'(overrun), 32'd1);
    end

    // Reset after four bits: outputs clear before any clock edge.
    start_frame();
    for (int i = 0; i < 4; i++) begin
      sin = 1'b1;
      tick();
    end
    #2 reset = 1'b1;
    #1;
    check("async_reset_outputs", {22'b0, d_out, valid, busy, overrun}, 32'd0);
    check("async_reset_msb_dout", 32'(d_out_m), 32'd0);
    #1 reset = 1'b0;
    tick();
    check("post_reset_idle", {30'b0, valid, busy}, 32'd0);
    start_frame();
    shift_bits(7'b1011001, -1);
    check("post_reset_word", 32'(d_out), 32'h59);
    check("post_reset_no_overrun", 32'(overrun), 32'd0);

    // Start while holding without ready: ignored for framing, flags overrun.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("hold_start_overrun", 32'(overrun), 32'd1);
    check("hold_start_valid", 32'(valid), 32'd1);
    check("hold_start_busy", 32'(busy), 32'd0);
    check("hold_start_dout", 32'(d_out), 32'h59);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("hold_release", 32'(valid), 32'd0);

    // MSB-first: 0,0,0,0,1,1,1 -> 0000111; LSB twin sees 1110000.
    start_frame();
    shift_bits(7'b1110000, -1);
    check("msb_word", 32'(d_out_m), 32'h07);
    check("msb_valid", 32'(valid_m), 32'd1);
    check("lsb_twin_word", 32'(d_out), 32'h70);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
